fp_normalize_round: RTL and testbench

//  Post-add normalizer and IEEE-754 single-precision rounder for the FP adder datapath.

---
 rtl/fp_normalize_round_pkg.sv | 36 +++
 rtl/fp_round_rne.sv | 47 ++++
 rtl/fp_normalize_round.sv | 149 ++++++++++++++
 tb/tb_fp_normalize_round.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fp_normalize_round_pkg.sv
// Shared widths, field positions, FSM states and result layout for the FP normalize/round block.
package fp_normalize_round_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = FRAC_W + 4;       // hidden + frac + G + R + S
  localparam int unsigned SUM_W  = MANT_W + 1;       // plus carry bit
  localparam int unsigned SIG_W  = FRAC_W + 1;       // hidden + frac
  localparam int unsigned RND_W  = SIG_W + 1;        // significand plus rounding carry
  localparam int unsigned IEXP_W = 10;               // signed working exponent
  localparam int unsigned RES_W  = 1 + EXP_W + FRAC_W;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam int unsigned CARRY_BIT  = 27;
  localparam int unsigned HIDDEN_BIT = 26;
  localparam int unsigned LSB_BIT    = 3;
  localparam int unsigned G_BIT      = 2;
  localparam int unsigned R_BIT      = 1;
  localparam int unsigned S_BIT      = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized (or subnormal) significand and field packing.
module fp_round_rne
  import fp_normalize_round_pkg::*;
(
  input  logic [MANT_W-1:0]        mant_i,
  input  logic signed [IEXP_W-1:0] exp_i,
  output logic [EXP_W-1:0]         exp_c,
  output logic [FRAC_W-1:0]        frac_c,
  output logic                     inexact_c,
  output logic                     overflow_c
);

  logic                     up;
  logic [RND_W-1:0]         sum;
  logic [SIG_W-1:0]         sig;
  logic signed [IEXP_W-1:0] exp_r;

  // Increment on G with R/S/LSB, renormalize on carry-out, then pack or saturate to infinity.
  always_comb begin
    up        = mant_i[G_BIT] & (mant_i[R_BIT] | mant_i[S_BIT] | mant_i[LSB_BIT]);
    inexact_c = |mant_i[G_BIT:S_BIT];
    sum       = {1'b0, mant_i[HIDDEN_BIT:LSB_BIT]} + RND_W'(up);
    if (sum[RND_W-1]) begin
      sig   = sum[RND_W-1:1];
      exp_r = exp_i + IEXP_W'(1);
    end else begin
      sig   = sum[SIG_W-1:0];
      exp_r = exp_i;
    end
    overflow_c = 1'b0;
    exp_c      = '0;
    frac_c     = sig[FRAC_W-1:0];
    if (sig[SIG_W-1]) begin
      if (exp_r >= IEXP_W'(EXP_MAX)) begin
        overflow_c = 1'b1;
        exp_c      = '1;
        frac_c     = '0;
      end else if (exp_r < IEXP_W'(1)) begin
        // A subnormal that rounded up into the hidden bit becomes the smallest normal.
        exp_c = EXP_W'(1);
      end else begin
        exp_c = exp_r[EXP_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-add normalizer and RNE rounder for single precision with valid/ready on both sides.
module fp_normalize_round
  import fp_normalize_round_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SUM_W-1:0] in_mant,
  input  logic             in_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_inexact,
  output logic             out_overflow
);

  state_e                   state_q, state_d;
  logic [SUM_W-1:0]         mant_q, mant_d;
  logic signed [IEXP_W-1:0] exp_q, exp_d;
  logic                     sign_q, sign_d;
  logic                     special_q, special_d;
  logic                     out_valid_q, out_valid_d;
  fp32_t                    result_q, result_d;
  logic                     inexact_q, inexact_d;
  logic                     overflow_q, overflow_d;

  logic                     capture;
  logic [EXP_W-1:0]         rnd_exp;
  logic [FRAC_W-1:0]        rnd_frac;
  logic                     rnd_inexact;
  logic                     rnd_overflow;

  fp_round_rne u_round (
    .mant_i     (mant_q[MANT_W-1:0]),
    .exp_i      (exp_q),
    .exp_c      (rnd_exp),
    .frac_c     (rnd_frac),
    .inexact_c  (rnd_inexact),
    .overflow_c (rnd_overflow)
  );

  // Accept when idle, or when the held result retires this same cycle.
  always_comb begin
    in_ready = (state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready);
    capture  = in_valid & in_ready;
  end

  // Next-state and datapath: one normalization step per NORM cycle, single-cycle round.
  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    special_d   = special_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    inexact_d   = inexact_q;
    overflow_d  = overflow_q;

    case (state_q)
      ST_IDLE: ;
      ST_NORM: begin
        if (special_q) begin
          state_d = ST_ROUND;
        end else if (mant_q == '0) begin
          exp_d   = '0;
          state_d = ST_ROUND;
        end else if (mant_q[CARRY_BIT]) begin
          // The bit shifted out folds into sticky.
          mant_d  = {1'b0, mant_q[SUM_W-1:2], mant_q[R_BIT] | mant_q[S_BIT]};
          exp_d   = exp_q + IEXP_W'(1);
          state_d = ST_ROUND;
        end else if (mant_q[HIDDEN_BIT]) begin
          state_d = ST_ROUND;
        end else if (exp_q > IEXP_W'(1)) begin
          mant_d  = mant_q << 1;
          exp_d   = exp_q - IEXP_W'(1);
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
        if (special_q) begin
          result_d   = '{sign: sign_q, exp: '1, frac: mant_q[HIDDEN_BIT-1:LSB_BIT]};
          inexact_d  = 1'b0;
          overflow_d = 1'b0;
        end else begin
          result_d   = '{sign: sign_q, exp: rnd_exp, frac: rnd_frac};
          inexact_d  = rnd_inexact;
          overflow_d = rnd_overflow;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          result_d    = '0;
          inexact_d   = 1'b0;
          overflow_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      mant_d    = {in_mant[SUM_W-1:1], in_mant[S_BIT] | in_sticky};
      exp_d     = IEXP_W'(in_exp);
      sign_d    = in_sign;
      special_d = &in_exp;
      state_d   = ST_NORM;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      special_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      inexact_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      special_q   <= special_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      inexact_q   <= inexact_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = result_q;
  assign out_inexact  = inexact_q;
  assign out_overflow = overflow_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for the FP normalize/round block.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_inexact;
  logic        out_overflow;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic        st;
    logic [31:0] r;
    logic        x;
    logic        o;
    int          lat;
  } vec_t;

  fp_normalize_round dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .in_sticky    (in_sticky),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_inexact  (out_inexact),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  // Presents one operand, waits (bounded) for the result and retires it.
  // lat counts cycles from the capture cycle (capture cycle = 0).
  task automatic drive_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                          input logic st, output logic [31:0] res, output logic inx,
                          output logic ovf, output int lat);
    @(negedge clk);
    in_sign = s; in_exp = e; in_mant = m; in_sticky = st;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sticky = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result; inx = out_inexact; ovf = out_overflow;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_result !== 32'h0) begin n_err++; $display("FAIL reset_out_result got %h want 00000000", out_result); end
    n_cmp++; if ({out_inexact, out_overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {out_inexact, out_overflow}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_renorm;
    vec_t v[4];
    logic [31:0] r; logic x, o; int lat;
    v[0] = '{"carry_renorm", 1'b0, 8'd127, 28'h8000000, 1'b0, 32'h40000000, 1'b0, 1'b0, 3};
    v[1] = '{"normalized",   1'b0, 8'd127, 28'h4000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3};
    v[2] = '{"neg_normal",   1'b1, 8'd127, 28'h4000000, 1'b0, 32'hBF800000, 1'b0, 1'b0, 3};
    v[3] = '{"left_shift3",  1'b0, 8'd127, 28'h0800000, 1'b0, 32'h3E000000, 1'b0, 1'b0, 6};
    foreach (v[i]) begin
      drive_op(v[i].s, v[i].e, v[i].m, v[i].st, r, x, o, lat);
      n_cmp++; if (r !== v[i].r) begin n_err++; $display("FAIL %s result got %h want %h", v[i].name, r, v[i].r); end
      n_cmp++; if ({x, o} !== {v[i].x, v[i].o}) begin n_err++; $display("FAIL %s flags got %b want %b", v[i].name, {x, o}, {v[i].x, v[i].o}); end
      n_cmp++; if (lat != v[i].lat) begin n_err++; $display("FAIL %s latency got %0d want %0d", v[i].name, lat, v[i].lat); end
    end
  endtask

  task automatic test_rounding;
    vec_t v[3];
    logic [31:0] r; logic x, o; int lat;
    v[0] = '{"rne_carry",   1'b0, 8'd127, 28'h7FFFFFC, 1'b0, 32'h40000000, 1'b1, 1'b0, 3};
    v[1] = '{"tie_even",    1'b0, 8'd127, 28'h4000004, 1'b0, 32'h3F800000, 1'b1, 1'b0, 3};
    v[2] = '{"sticky_only", 1'b0, 8'd127, 28'h4000000, 1'b1, 32'h3F800000, 1'b1, 1'b0, 3};
    foreach (v[i]) begin
      drive_op(v[i].s, v[i].e, v[i].m, v[i].st, r, x, o, lat);
      n_cmp++; if (r !== v[i].r) begin n_err++; $display("FAIL %s result got %h want %h", v[i].name, r, v[i].r); end
      n_cmp++; if ({x, o} !== {v[i].x, v[i].o}) begin n_err++; $display("FAIL %s flags got %b want %b", v[i].name, {x, o}, {v[i].x, v[i].o}); end
      n_cmp++; if (lat != v[i].lat) begin n_err++; $display("FAIL %s latency got %0d want %0d", v[i].name, lat, v[i].lat); end
    end
  endtask

  task automatic test_specials;
    vec_t v[6];
    logic [31:0] r; logic x, o; int lat;
    v[0] = '{"overflow",       1'b0, 8'd254, 28'h8000000, 1'b0, 32'h7F800000, 1'b0, 1'b1, 3};
    v[1] = '{"round_overflow", 1'b1, 8'd254, 28'h7FFFFFC, 1'b0, 32'hFF800000, 1'b1, 1'b1, 3};
    v[2] = '{"signed_zero",    1'b1, 8'd100, 28'h0000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 3};
    v[3] = '{"exp_ff_pass",    1'b0, 8'hFF,  28'h400000C, 1'b0, 32'h7F800001, 1'b0, 1'b0, 3};
    v[4] = '{"subnormal",      1'b0, 8'd3,   28'h0800000, 1'b0, 32'h00400000, 1'b0, 1'b0, 5};
    v[5] = '{"sub_to_normal",  1'b0, 8'd1,   28'h3FFFFFC, 1'b0, 32'h00800000, 1'b1, 1'b0, 3};
    foreach (v[i]) begin
      drive_op(v[i].s, v[i].e, v[i].m, v[i].st, r, x, o, lat);
      n_cmp++; if (r !== v[i].r) begin n_err++; $display("FAIL %s result got %h want %h", v[i].name, r, v[i].r); end
      n_cmp++; if ({x, o} !== {v[i].x, v[i].o}) begin n_err++; $display("FAIL %s flags got %b want %b", v[i].name, {x, o}, {v[i].x, v[i].o}); end
      n_cmp++; if (lat != v[i].lat) begin n_err++; $display("FAIL %s latency got %0d want %0d", v[i].name, lat, v[i].lat); end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h4000000; in_sticky = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL bp_first_latency got %0d want 3", lat); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", c, out_valid); end
      n_cmp++; if (out_result !== 32'h3F800000) begin n_err++; $display("FAIL bp_hold_result cycle %0d got %h want 3f800000", c, out_result); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_in_ready cycle %0d got %b want 0", c, in_ready); end
    end
    @(negedge clk);
    in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h8000000;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_retired got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy_in_ready got %b want 0", in_ready); end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL b2b_latency got %0d want 3", lat); end
    n_cmp++; if (out_result !== 32'h40000000) begin n_err++; $display("FAIL b2b_result got %h want 40000000", out_result); end
    @(posedge clk); #1;
    n_cmp++; if ({out_valid, out_result} !== 33'h0) begin n_err++; $display("FAIL b2b_clear got %b/%h want 0/00000000", out_valid, out_result); end
  endtask

  task automatic test_async_reset;
    logic [31:0] r; logic x, o; int lat;
    @(negedge clk);
    in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h0800000; in_sticky = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL arst_pre_in_ready got %b want 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_discarded got %b want 0", out_valid); end
    drive_op(1'b0, 8'd127, 28'h4000000, 1'b0, r, x, o, lat);
    n_cmp++; if (r !== 32'h3F800000) begin n_err++; $display("FAIL arst_next_result got %h want 3f800000", r); end
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL arst_next_latency got %0d want 3", lat); end
  endtask

  initial begin
    test_reset();
    test_renorm();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
